// File: rtl/int_to_float_pipe.sv
// int_to_float_pipe
//   Pipelined signed/unsigned integer to IEEE-754 binary32 converter with all five
//   RISC-V rounding modes. Three compute stages plus a registered output stage.
//   Every rank advances together on adv = !out_valid || out_ready. Bubbles are not
//   compacted.
//
// Ports
//   clk, rst_l      clock; asynchronous active-low reset
//   flush           synchronous kill of every in-flight operation (and of the offered input)
//   in_valid/ready  operand handshake; in_ready = adv
//   signed_in, num  operand and its signedness
//   round_mode      000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM (others behave as RTZ)
//   in_tag          sideband tag, returned unchanged on out_tag
//   out_valid/ready result handshake
//   out             {sign, exp, frac}
//   exceptions      {NV, DZ, OF, UF, NX}
//   out_tag         tag of the presented result

module int_to_float_pipe #(
  parameter int unsigned INT_WIDTH = 32,  // 32 or 64
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned SIG_WIDTH = 24,
  parameter int unsigned TAG_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_l,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           signed_in,
  input  logic [INT_WIDTH-1:0]           num,
  input  logic [2:0]                     round_mode,
  input  logic [TAG_WIDTH-1:0]           in_tag,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [EXP_WIDTH+SIG_WIDTH-1:0] out,
  output logic [4:0]                     exceptions,
  output logic [TAG_WIDTH-1:0]           out_tag
);

  localparam int unsigned IDX_W = $clog2(INT_WIDTH);
  // 24 significand bits + guard + round + sticky
  localparam int unsigned RND_W = SIG_WIDTH + 3;
  localparam int unsigned OUT_W = EXP_WIDTH + SIG_WIDTH;
  localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(INT_WIDTH - 1);
  localparam logic [EXP_WIDTH-1:0] EXP_BIAS = EXP_WIDTH'((1 << (EXP_WIDTH - 1)) - 1);

  logic adv;

  // Stage 1 state
  logic                 s1_valid_q;
  logic                 s1_sign_q;
  logic [INT_WIDTH-1:0] s1_mag_q;
  logic                 s1_zero_q;
  logic [2:0]           s1_rm_q;
  logic [TAG_WIDTH-1:0] s1_tag_q;

  // Stage 2 state
  logic                 s2_valid_q;
  logic                 s2_sign_q;
  logic                 s2_zero_q;
  logic [2:0]           s2_rm_q;
  logic [TAG_WIDTH-1:0] s2_tag_q;
  logic [IDX_W-1:0]     s2_idx_q;
  logic [RND_W-1:0]     s2_rnd_q;

  // Stage 3 state
  logic                 s3_valid_q;
  logic                 s3_sign_q;
  logic                 s3_zero_q;
  logic [TAG_WIDTH-1:0] s3_tag_q;
  logic [IDX_W-1:0]     s3_idx_q;
  logic [SIG_WIDTH-1:0] s3_sig_q;
  logic                 s3_inc_q;
  logic                 s3_nx_q;

  // Output state
  logic                 out_valid_q;
  logic [OUT_W-1:0]     out_q;
  logic [4:0]           exc_q;
  logic [TAG_WIDTH-1:0] tag_q;

  // Next-state signals
  logic                 s1_sign_d;
  logic [INT_WIDTH-1:0] s1_mag_d;
  logic                 s1_zero_d;
  logic [IDX_W-1:0]     s2_idx_d;
  logic [INT_WIDTH-1:0] s2_norm;
  logic [RND_W-1:0]     s2_rnd_d;
  logic                 rnd_lsb, rnd_g, rnd_r, rnd_s, rnd_any;
  logic                 s3_inc_d;
  logic [SIG_WIDTH:0]   rnd_sum;
  logic [EXP_WIDTH-1:0] res_exp;
  logic [OUT_W-1:0]     out_d;
  logic [4:0]           exc_d;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------------------
  // Stage 1: sign and magnitude. Negating the most-negative value wraps to
  // 2^(INT_WIDTH-1), which is exactly the magnitude wanted.
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_sign_d = signed_in & num[INT_WIDTH-1];
    s1_mag_d  = s1_sign_d ? -num : num;
    s1_zero_d = (num == '0);
  end

  // ---------------------------------------------------------------------------
  // Stage 2: leading-one detect, normalise, compress to 27 bits.
  // ---------------------------------------------------------------------------
  always_comb begin
    s2_idx_d = '0;
    for (int unsigned i = 0; i < INT_WIDTH; i++) begin
      if (s1_mag_q[i]) s2_idx_d = IDX_W'(i);
    end
  end

  always_comb begin
    s2_norm  = s1_mag_q << (TOP_IDX - s2_idx_d);
    // Everything below the round bit folds into sticky.
    s2_rnd_d = {s2_norm[INT_WIDTH-1 -: RND_W-1], |s2_norm[INT_WIDTH-RND_W:0]};
  end

  // ---------------------------------------------------------------------------
  // Stage 3: rounding decision.
  // ---------------------------------------------------------------------------
  always_comb begin
    rnd_lsb  = s2_rnd_q[3];
    rnd_g    = s2_rnd_q[2];
    rnd_r    = s2_rnd_q[1];
    rnd_s    = s2_rnd_q[0];
    rnd_any  = rnd_g | rnd_r | rnd_s;
    s3_inc_d = 1'b0;
    case (s2_rm_q)
      3'b000:  s3_inc_d = rnd_g & (rnd_r | rnd_s | rnd_lsb);
      3'b001:  s3_inc_d = 1'b0;
      3'b010:  s3_inc_d = s2_sign_q & rnd_any;
      3'b011:  s3_inc_d = !s2_sign_q & rnd_any;
      3'b100:  s3_inc_d = rnd_g;
      default: s3_inc_d = 1'b0;  // reserved encodings truncate
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output stage: apply increment and pack. A carry out of the significand leaves
  // the low 24 sum bits at zero, so the fraction clears on its own.
  // ---------------------------------------------------------------------------
  always_comb begin
    rnd_sum = {1'b0, s3_sig_q} + (SIG_WIDTH + 1)'(s3_inc_q);
    res_exp = EXP_WIDTH'(s3_idx_q) + EXP_BIAS + EXP_WIDTH'(rnd_sum[SIG_WIDTH]);
    out_d   = s3_zero_q ? '0 : {s3_sign_q, res_exp, rnd_sum[SIG_WIDTH-2:0]};
    // Integers never reach 2^128, so only inexact can be raised.
    exc_d   = s3_zero_q ? 5'b00000 : {4'b0000, s3_nx_q};
  end

  // ---------------------------------------------------------------------------
  // Valid chain
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s3_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      s1_valid_q  <= in_valid;
      s2_valid_q  <= s1_valid_q;
      s3_valid_q  <= s2_valid_q;
      out_valid_q <= s3_valid_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Data path registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      s1_sign_q <= 1'b0;
      s1_mag_q  <= '0;
      s1_zero_q <= 1'b0;
      s1_rm_q   <= '0;
      s1_tag_q  <= '0;
      s2_sign_q <= 1'b0;
      s2_zero_q <= 1'b0;
      s2_rm_q   <= '0;
      s2_tag_q  <= '0;
      s2_idx_q  <= '0;
      s2_rnd_q  <= '0;
      s3_sign_q <= 1'b0;
      s3_zero_q <= 1'b0;
      s3_tag_q  <= '0;
      s3_idx_q  <= '0;
      s3_sig_q  <= '0;
      s3_inc_q  <= 1'b0;
      s3_nx_q   <= 1'b0;
      out_q     <= '0;
      exc_q     <= '0;
      tag_q     <= '0;
    end else if (adv) begin
      s1_sign_q <= s1_sign_d;
      s1_mag_q  <= s1_mag_d;
      s1_zero_q <= s1_zero_d;
      s1_rm_q   <= round_mode;
      s1_tag_q  <= in_tag;

      s2_sign_q <= s1_sign_q;
      s2_zero_q <= s1_zero_q;
      s2_rm_q   <= s1_rm_q;
      s2_tag_q  <= s1_tag_q;
      s2_idx_q  <= s2_idx_d;
      s2_rnd_q  <= s2_rnd_d;

      s3_sign_q <= s2_sign_q;
      s3_zero_q <= s2_zero_q;
      s3_tag_q  <= s2_tag_q;
      s3_idx_q  <= s2_idx_q;
      s3_sig_q  <= s2_rnd_q[RND_W-1:3];
      s3_inc_q  <= s3_inc_d;
      s3_nx_q   <= rnd_any;

      // Only a real result replaces the presented one.
      if (s3_valid_q) begin
        out_q <= out_d;
        exc_q <= exc_d;
        tag_q <= s3_tag_q;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out        = out_q;
  assign exceptions = exc_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_int_to_float_pipe.sv
module tb_int_to_float_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_l, flush, out_ready;

  // 32-bit instance
  logic        a_in_valid, a_in_ready, a_signed, a_out_valid;
  logic [31:0] a_num, a_out;
  logic [2:0]  a_rm;
  logic [3:0]  a_in_tag, a_out_tag;
  logic [4:0]  a_exc;

  // 64-bit instance
  logic        b_in_valid, b_in_ready, b_signed, b_out_valid;
  logic [63:0] b_num;
  logic [31:0] b_out;
  logic [2:0]  b_rm;
  logic [3:0]  b_in_tag, b_out_tag;
  logic [4:0]  b_exc;

  int_to_float_pipe #(.INT_WIDTH(32)) dut_a (
    .clk(clk), .rst_l(rst_l), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .signed_in(a_signed), .num(a_num),
    .round_mode(a_rm), .in_tag(a_in_tag), .out_valid(a_out_valid), .out_ready(out_ready),
    .out(a_out), .exceptions(a_exc), .out_tag(a_out_tag)
  );

  int_to_float_pipe #(.INT_WIDTH(64)) dut_b (
    .clk(clk), .rst_l(rst_l), .flush(flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .signed_in(b_signed), .num(b_num),
    .round_mode(b_rm), .in_tag(b_in_tag), .out_valid(b_out_valid), .out_ready(out_ready),
    .out(b_out), .exceptions(b_exc), .out_tag(b_out_tag)
  );

  typedef struct {
    logic [31:0] res;
    logic [4:0]  exc;
    logic [3:0]  tag;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
    end
  endtask

  // Scoreboards: compare on every output handshake, and check hold-stability while stalled.
  logic        a_stall_prev = 1'b0, b_stall_prev = 1'b0;
  logic [40:0] a_hold, b_hold;

  always @(negedge clk) begin
    exp_t e;
    if (rst_l && a_out_valid) begin
      if (a_stall_prev) check("a_hold", 64'({a_out, a_exc, a_out_tag}), 64'(a_hold));
      if (out_ready) begin
        n_cmp++;
        assert (qa.size() != 0) else begin
          n_err++;
          $error("FAIL a_unexpected: observed tag %0d expected no output", a_out_tag);
        end
        if (qa.size() != 0) begin
          e = qa.pop_front();
          check("a_result", 64'({a_out, a_exc, a_out_tag}), 64'({e.res, e.exc, e.tag}));
          if (e.chk_lat) check("a_latency", 64'(cyc - e.acc_cyc), 64'd3);
        end
      end
      a_stall_prev <= !out_ready;
      a_hold       <= {a_out, a_exc, a_out_tag};
    end else begin
      a_stall_prev <= 1'b0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_l && b_out_valid) begin
      if (b_stall_prev) check("b_hold", 64'({b_out, b_exc, b_out_tag}), 64'(b_hold));
      if (out_ready) begin
        n_cmp++;
        assert (qb.size() != 0) else begin
          n_err++;
          $error("FAIL b_unexpected: observed tag %0d expected no output", b_out_tag);
        end
        if (qb.size() != 0) begin
          e = qb.pop_front();
          check("b_result", 64'({b_out, b_exc, b_out_tag}), 64'({e.res, e.exc, e.tag}));
          if (e.chk_lat) check("b_latency", 64'(cyc - e.acc_cyc), 64'd3);
        end
      end
      b_stall_prev <= !out_ready;
      b_hold       <= {b_out, b_exc, b_out_tag};
    end else begin
      b_stall_prev <= 1'b0;
    end
  end

  task automatic send_a(input logic sgn, input logic [31:0] n, input logic [2:0] rm,
                        input logic [3:0] tag, input logic [31:0] res, input logic [4:0] exc,
                        input bit lat);
    a_in_valid = 1'b1; a_signed = sgn; a_num = n; a_rm = rm; a_in_tag = tag;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_in_ready) begin
        qa.push_back('{res, exc, tag, cyc + 1, lat});
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++; n_err++;
    $error("FAIL a_accept_timeout: observed in_ready 0 expected 1 within 50 cycles");
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic sgn, input logic [63:0] n, input logic [2:0] rm,
                        input logic [3:0] tag, input logic [31:0] res, input logic [4:0] exc);
    b_in_valid = 1'b1; b_signed = sgn; b_num = n; b_rm = rm; b_in_tag = tag;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b_in_ready) begin
        qb.push_back('{res, exc, tag, cyc + 1, 1'b1});
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    n_cmp++; n_err++;
    $error("FAIL b_accept_timeout: observed in_ready 0 expected 1 within 50 cycles");
    b_in_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (qa.size() == 0 && qb.size() == 0) return;
      @(posedge clk); #2;
    end
    n_cmp++;
    assert (qa.size() == 0 && qb.size() == 0) else begin
      n_err++;
      $error("FAIL drain: observed %0d/%0d pending expected 0/0", qa.size(), qb.size());
    end
  endtask

  logic [31:0] bp_res [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                              32'h40800000, 32'h40A00000, 32'h40C00000};

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_l = 1'b0; flush = 1'b0; out_ready = 1'b0;
    a_in_valid = 1'b0; a_signed = 1'b0; a_num = '0; a_rm = '0; a_in_tag = '0;
    b_in_valid = 1'b0; b_signed = 1'b0; b_num = '0; b_rm = '0; b_in_tag = '0;

    // Reset state
    #12;
    check("rst_a_out_valid", 64'(a_out_valid), 64'd0);
    check("rst_a_regs", 64'({a_out, a_exc, a_out_tag}), 64'd0);
    check("rst_a_in_ready", 64'(a_in_ready), 64'd1);
    check("rst_b_out_valid", 64'(b_out_valid), 64'd0);
    check("rst_b_regs", 64'({b_out, b_exc, b_out_tag}), 64'd0);
    @(negedge clk); rst_l = 1'b1;
    @(posedge clk); #1; out_ready = 1'b1;

    // 32-bit directed conversions, back to back
    send_a(1'b0, 32'h00000001, 3'b000, 4'd1,  32'h3F800000, 5'b00000, 1'b1);
    send_a(1'b1, 32'hFFFFFFFF, 3'b000, 4'd2,  32'hBF800000, 5'b00000, 1'b1);
    send_a(1'b1, 32'h80000000, 3'b000, 4'd3,  32'hCF000000, 5'b00000, 1'b1);
    send_a(1'b0, 32'hFFFFFFFF, 3'b000, 4'd4,  32'h4F800000, 5'b00001, 1'b1);
    send_a(1'b0, 32'h01000001, 3'b000, 4'd5,  32'h4B800000, 5'b00001, 1'b1);
    send_a(1'b0, 32'h01000001, 3'b011, 4'd6,  32'h4B800001, 5'b00001, 1'b1);
    send_a(1'b0, 32'h01000001, 3'b001, 4'd7,  32'h4B800000, 5'b00001, 1'b1);
    send_a(1'b1, 32'hFEFFFFFF, 3'b010, 4'd8,  32'hCB800001, 5'b00001, 1'b1);
    send_a(1'b1, 32'hFEFFFFFF, 3'b100, 4'd9,  32'hCB800001, 5'b00001, 1'b1);
    send_a(1'b1, 32'hFEFFFFFF, 3'b011, 4'd10, 32'hCB800000, 5'b00001, 1'b1);
    send_a(1'b0, 32'hFFFFFFFF, 3'b001, 4'd11, 32'h4F7FFFFF, 5'b00001, 1'b1);
    send_a(1'b0, 32'hFFFFFFFF, 3'b111, 4'd12, 32'h4F7FFFFF, 5'b00001, 1'b1);
    send_a(1'b1, 32'h00000000, 3'b000, 4'd13, 32'h00000000, 5'b00000, 1'b1);
    send_a(1'b0, 32'h01000003, 3'b000, 4'd14, 32'h4B800002, 5'b00001, 1'b1);
    drain(20);

    // 64-bit directed conversions
    send_b(1'b0, 64'hFFFFFFFFFFFFFFFF, 3'b000, 4'd1, 32'h5F800000, 5'b00001);
    send_b(1'b0, 64'h0000000000000000, 3'b000, 4'd2, 32'h00000000, 5'b00000);
    send_b(1'b1, 64'h8000000000000000, 3'b000, 4'd3, 32'hDF000000, 5'b00000);
    send_b(1'b0, 64'h0000000000000003, 3'b000, 4'd4, 32'h40400000, 5'b00000);
    send_b(1'b1, 64'hFFFFFFFFFFFFFFFF, 3'b011, 4'd5, 32'hBF800000, 5'b00000);
    send_b(1'b0, 64'h0020000000000001, 3'b000, 4'd6, 32'h5A000000, 5'b00001);
    send_b(1'b0, 64'h0020000000000001, 3'b011, 4'd7, 32'h5A000001, 5'b00001);
    drain(20);

    // Backpressure: six inputs, consumer stalled for five cycles
    fork
      begin
        for (int t = 0; t < 6; t++)
          send_a(1'b0, 32'(t + 1), 3'b000, 4'(t), bp_res[t], 5'b00000, 1'b0);
      end
      begin
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bp_in_ready_low", 64'(a_in_ready), 64'd0);
        check("bp_out_valid_held", 64'(a_out_valid), 64'd1);
        out_ready = 1'b1;
      end
    join
    drain(30);

    // Flush with three operations in flight; the input offered alongside is dropped
    send_a(1'b0, 32'd100, 3'b000, 4'd1, 32'h42C80000, 5'b00000, 1'b0);
    send_a(1'b0, 32'd200, 3'b000, 4'd2, 32'h43480000, 5'b00000, 1'b0);
    send_a(1'b0, 32'd300, 3'b000, 4'd3, 32'h43960000, 5'b00000, 1'b0);
    flush = 1'b1;
    a_in_valid = 1'b1; a_num = 32'd7; a_in_tag = 4'd7;
    @(posedge clk); #1;
    flush = 1'b0; a_in_valid = 1'b0;
    qa.delete();
    check("flush_out_valid", 64'(a_out_valid), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    send_a(1'b0, 32'h00000002, 3'b000, 4'd9, 32'h40000000, 5'b00000, 1'b1);
    drain(20);

    // Asynchronous reset while results are in flight and one is presented
    for (int t = 0; t < 5; t++)
      send_a(1'b0, 32'h00000001, 3'b000, 4'(t), 32'h3F800000, 5'b00000, 1'b0);
    check("pre_rst_out_valid", 64'(a_out_valid), 64'd1);
    #2; rst_l = 1'b0;
    #1;
    check("async_rst_out_valid", 64'(a_out_valid), 64'd0);
    check("async_rst_in_ready", 64'(a_in_ready), 64'd1);
    qa.delete();
    @(negedge clk); rst_l = 1'b1;
    @(posedge clk); #1;
    send_a(1'b1, 32'hFFFFFFFE, 3'b000, 4'd6, 32'hC0000000, 5'b00000, 1'b1);
    drain(20);
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
